tdc_event_sequencer: RTL and testbench

Upstream stage of the SiFH pipeline: turns a sparse, per-acquisition stream of TDC timestamps tagged with pixel IDs into the dense, strictly ordered word stream the histogram builder consumes. The histogram builder expects this order: one word per `wrEn` cycle, `DATA_NUM` words per pixel, pixels `0..PIXEL_NUM-1`. Pixel slots with no event are padded with the all-ones invalid marker. Surplus or out-of-order events are dropped.

---
 rtl/sifh_pkg.sv | 16 +
 rtl/seq_hold_reg.sv | 43 ++++
 rtl/tdc_event_sequencer.sv | 143 ++++++++++++++
 tb/tb_tdc_event_sequencer.sv | 401 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sifh_pkg.sv
// sifh_pkg: shared constants and types for the SiFH front-end pipeline.
// Holds the default geometry, the pad marker and the sequencer FSM state type.
package sifh_pkg;

    localparam int NP        = 16;
    localparam int DATA_NUM  = 4;
    localparam int PIXEL_NUM = 8;

    localparam logic [NP-1:0] PAD_WORD = {NP{1'b1}};

    typedef enum logic {
        COLLECT = 1'b0,
        FLUSH   = 1'b1
    } seq_state_t;

endpackage

// File: rtl/seq_hold_reg.sv
// seq_hold_reg: one-entry valid/ready hold register in front of the sequencer.
// Ports: clk, res (async active-low), collect/consume from the sequencer,
//        in_valid/in_ready/in_pix/in_ts/in_last upstream, hv/hpix/hts/hlast held entry.
module seq_hold_reg #(
    parameter int NP    = 16,
    parameter int PIX_W = 3
) (
    input  logic             clk,
    input  logic             res,
    input  logic             collect,
    input  logic             consume,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [PIX_W-1:0] in_pix,
    input  logic [NP-1:0]    in_ts,
    input  logic             in_last,
    output logic             hv,
    output logic [PIX_W-1:0] hpix,
    output logic [NP-1:0]    hts,
    output logic             hlast
);

    // consume is computed from registered state only, so no
    // combinational path exists from in_valid to in_ready.
    assign in_ready = collect && (!hv || consume);

    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            hv    <= 1'b0;
            hpix  <= '0;
            hts   <= '0;
            hlast <= 1'b0;
        end else if (in_valid && in_ready) begin
            hv    <= 1'b1;
            hpix  <= in_pix;
            hts   <= in_ts;
            hlast <= in_last;
        end else if (consume) begin
            hv    <= 1'b0;
        end
    end

endmodule

// File: rtl/tdc_event_sequencer.sv
// tdc_event_sequencer: orders sparse pixel-tagged TDC events into the dense
// DATA_NUM-words-per-pixel stream, padding gaps with all-ones and dropping strays.
// Ports: clk, res (async active-low), in_valid/in_ready/in_pix/in_ts/in_last in,
//        wrEn/data/acq_done out; drop_cnt/pad_cnt only when SEQ_STATS_EN is defined.
module tdc_event_sequencer #(
    parameter int NP        = sifh_pkg::NP,
    parameter int DATA_NUM  = sifh_pkg::DATA_NUM,
    parameter int PIXEL_NUM = sifh_pkg::PIXEL_NUM,
    parameter int PIX_W     = $clog2(PIXEL_NUM)
) (
    input  logic             clk,
    input  logic             res,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [PIX_W-1:0] in_pix,
    input  logic [NP-1:0]    in_ts,
    input  logic             in_last,
    output logic             wrEn,
    output logic [NP-1:0]    data,
`ifdef SEQ_STATS_EN
    output logic             acq_done,
    output logic [15:0]      drop_cnt,
    output logic [15:0]      pad_cnt
`else
    output logic             acq_done
`endif
);

    import sifh_pkg::*;

    localparam int SW = (DATA_NUM > 1) ? $clog2(DATA_NUM) : 1;
    localparam logic [NP-1:0] PAD = {NP{1'b1}};

    seq_state_t       state;
    logic [PIX_W-1:0] p;
    logic [SW-1:0]    s;

    logic             hv;
    logic [PIX_W-1:0] hpix;
    logic [NP-1:0]    hts;
    logic             hlast;

    logic             consume;
    logic             emit;
    logic             pad;
    logic             drop;
    logic             at_end;
    logic             wrap;
    logic             go_flush;
    logic             s_last;
    logic [31:0]      hpix_w;

    seq_hold_reg #(
        .NP    (NP),
        .PIX_W (PIX_W)
    ) u_hold (
        .clk      (clk),
        .res      (res),
        .collect  (state == COLLECT),
        .consume  (consume),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_pix   (in_pix),
        .in_ts    (in_ts),
        .in_last  (in_last),
        .hv       (hv),
        .hpix     (hpix),
        .hts      (hts),
        .hlast    (hlast)
    );

    assign hpix_w = 32'(hpix);
    assign s_last = (s == SW'(DATA_NUM - 1));
    assign at_end = (p == PIX_W'(PIXEL_NUM - 1)) && s_last;

    // Exactly one outcome per cycle for the held event: drop, emit, or pad.
    always_comb begin
        consume = 1'b0;
        emit    = 1'b0;
        pad     = 1'b0;
        drop    = 1'b0;
        if (state == COLLECT && hv) begin
            if (hpix_w >= 32'(PIXEL_NUM) || hpix < p) begin
                drop    = 1'b1;
                consume = 1'b1;
            end else if (hpix == p) begin
                emit    = 1'b1;
                consume = 1'b1;
            end else begin
                emit    = 1'b1;
                pad     = 1'b1;
            end
        end else if (state == FLUSH) begin
            emit = 1'b1;
            pad  = 1'b1;
        end
    end

    assign wrap = emit && at_end;

    // A last event whose own word closes the acquisition needs no flush.
    assign go_flush = consume && hlast && !wrap;

    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            state    <= COLLECT;
            p        <= '0;
            s        <= '0;
            wrEn     <= 1'b0;
            data     <= '0;
            acq_done <= 1'b0;
        end else begin
            wrEn     <= emit;
            acq_done <= wrap;
            if (emit) begin
                data <= pad ? PAD : hts;
                if (s_last) begin
                    s <= '0;
                    p <= at_end ? '0 : p + 1'b1;
                end else begin
                    s <= s + 1'b1;
                end
            end
            unique case (state)
                COLLECT: if (go_flush) state <= FLUSH;
                FLUSH:   if (at_end)   state <= COLLECT;
            endcase
        end
    end

`ifdef SEQ_STATS_EN
    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            drop_cnt <= '0;
            pad_cnt  <= '0;
        end else begin
            if (drop && drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 1'b1;
            if (pad  && pad_cnt  != 16'hFFFF) pad_cnt  <= pad_cnt + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_tdc_event_sequencer.sv
// tb_tdc_event_sequencer: directed self-checking bench for tdc_event_sequencer.
// Drives pixel-tagged events and checks the ordered/padded output word stream.
module tb_tdc_event_sequencer;

    logic        clk;
    logic        res;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  in_pix;
    logic [15:0] in_ts;
    logic        in_last;
    logic        wrEn;
    logic [15:0] data;
    logic        acq_done;
`ifdef SEQ_STATS_EN
    logic [15:0] drop_cnt;
    logic [15:0] pad_cnt;
`endif

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    logic [15:0] q_data[$];
    bit          q_done[$];
    bit          q_rdy[$];
    int          q_cyc[$];
    int          done_nowr;

    tdc_event_sequencer dut (
        .clk      (clk),
        .res      (res),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_pix   (in_pix),
        .in_ts    (in_ts),
        .in_last  (in_last),
        .wrEn     (wrEn),
        .data     (data),
`ifdef SEQ_STATS_EN
        .acq_done (acq_done),
        .drop_cnt (drop_cnt),
        .pad_cnt  (pad_cnt)
`else
        .acq_done (acq_done)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (wrEn) begin
            q_data.push_back(data);
            q_done.push_back(acq_done);
            q_rdy.push_back(in_ready);
            q_cyc.push_back(cyc);
        end else if (acq_done) begin
            done_nowr++;
        end
    end

    task automatic clear_q();
        q_data.delete();
        q_done.delete();
        q_rdy.delete();
        q_cyc.delete();
        done_nowr = 0;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        res      = 1'b0;
        in_valid = 1'b0;
        in_last  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        res = 1'b1;
        clear_q();
    endtask

    task automatic drain(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send(input int pix, input logic [15:0] ts,
                        input bit last, output int stall);
        int n;
        bit got;
        bit rdy;
        n     = 0;
        got   = 0;
        stall = 0;
        in_valid = 1'b1;
        in_pix   = 3'(pix);
        in_ts    = ts;
        in_last  = last;
        while (!got && n < 200) begin
            @(negedge clk);
            rdy = in_ready;
            @(posedge clk);
            #1;
            if (rdy) got = 1;
            else stall++;
            n++;
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        total++;
        if (!got) begin
            bad++;
            $display("FAIL send_timeout pix=%0d ts=%h not accepted in 200 cycles",
                     pix, ts);
        end
    endtask

    task automatic test_reset();
        res      = 1'b0;
        in_valid = 1'b1;
        in_pix   = 3'd0;
        in_ts    = 16'h5555;
        in_last  = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        total++;
        if (wrEn !== 1'b0) begin
            bad++;
            $display("FAIL reset_wrEn got=%b exp=0", wrEn);
        end
        total++;
        if (data !== 16'h0000) begin
            bad++;
            $display("FAIL reset_data got=%h exp=0000", data);
        end
        total++;
        if (acq_done !== 1'b0) begin
            bad++;
            $display("FAIL reset_acq_done got=%b exp=0", acq_done);
        end
        @(posedge clk);
        #1;
        res      = 1'b1;
        in_valid = 1'b0;
        @(negedge clk);
        total++;
        if (in_ready !== 1'b1) begin
            bad++;
            $display("FAIL reset_in_ready got=%b exp=1", in_ready);
        end
        drain(1);
    endtask

    task automatic test_latency();
        int st;
        do_reset();
        send(0, 16'h1234, 0, st);
        @(negedge clk);
        total++;
        if (wrEn !== 1'b0) begin
            bad++;
            $display("FAIL latency_early got wrEn=%b exp=0", wrEn);
        end
        @(negedge clk);
        total++;
        if (wrEn !== 1'b1 || data !== 16'h1234) begin
            bad++;
            $display("FAIL latency_word got wrEn=%b data=%h exp wrEn=1 data=1234",
                     wrEn, data);
        end
    endtask

    task automatic test_full_acq();
        int st;
        int nerr;
        logic [15:0] exp_ts[32];
        do_reset();
        for (int i = 0; i < 32; i++) begin
            exp_ts[i] = (i == 5) ? 16'hFFFF : 16'hA000 + 16'(i);
            send(i / 4, exp_ts[i], i == 31, st);
        end
        drain(4);
        total++;
        if (q_data.size() !== 32) begin
            bad++;
            $display("FAIL full_count got=%0d exp=32", q_data.size());
        end else begin
            nerr = 0;
            for (int i = 0; i < 32; i++)
                if (q_data[i] !== exp_ts[i] || q_done[i] !== (i == 31)) nerr++;
            total++;
            if (nerr != 0) begin
                bad++;
                $display("FAIL full_words got %0d wrong words/done flags exp 0", nerr);
            end
            total++;
            if (q_cyc[31] - q_cyc[0] != 31) begin
                bad++;
                $display("FAIL full_contig got span=%0d exp=31", q_cyc[31] - q_cyc[0]);
            end
        end
        total++;
        if (done_nowr != 0) begin
            bad++;
            $display("FAIL full_stray_done got=%0d exp=0", done_nowr);
        end
`ifdef SEQ_STATS_EN
        total++;
        if (pad_cnt !== 16'd0) begin
            bad++;
            $display("FAIL full_pad_cnt got=%0d exp=0", pad_cnt);
        end
`endif
    endtask

    task automatic test_gap();
        int st;
        int nerr;
        logic [15:0] exp_w[14];
        do_reset();
        exp_w[0] = 16'h0100;
        exp_w[1] = 16'h0101;
        for (int i = 2; i < 12; i++) exp_w[i] = 16'hFFFF;
        exp_w[12] = 16'h0300;
        exp_w[13] = 16'h0301;
        send(0, 16'h0100, 0, st);
        send(0, 16'h0101, 0, st);
        send(3, 16'h0300, 0, st);
        send(3, 16'h0301, 0, st);
        total++;
        if (st != 10) begin
            bad++;
            $display("FAIL gap_stall got=%0d exp=10", st);
        end
        drain(4);
        total++;
        if (q_data.size() !== 14) begin
            bad++;
            $display("FAIL gap_count got=%0d exp=14", q_data.size());
        end else begin
            nerr = 0;
            for (int i = 0; i < 14; i++)
                if (q_data[i] !== exp_w[i] || q_done[i] !== 1'b0) nerr++;
            total++;
            if (nerr != 0) begin
                bad++;
                $display("FAIL gap_words got %0d wrong words exp 0", nerr);
            end
        end
`ifdef SEQ_STATS_EN
        total++;
        if (pad_cnt !== 16'd10) begin
            bad++;
            $display("FAIL gap_pad_cnt got=%0d exp=10", pad_cnt);
        end
`endif
    endtask

    task automatic test_surplus();
        int st;
        int nerr;
        logic [15:0] exp_w[6];
        do_reset();
        for (int i = 0; i < 5; i++) send(0, 16'h0A00 + 16'(i), 0, st);
        send(1, 16'h0B00, 0, st);
        send(0, 16'h0C00, 0, st);
        send(1, 16'h0B01, 0, st);
        drain(4);
        exp_w[0] = 16'h0A00;
        exp_w[1] = 16'h0A01;
        exp_w[2] = 16'h0A02;
        exp_w[3] = 16'h0A03;
        exp_w[4] = 16'h0B00;
        exp_w[5] = 16'h0B01;
        total++;
        if (q_data.size() !== 6) begin
            bad++;
            $display("FAIL surplus_count got=%0d exp=6", q_data.size());
        end else begin
            nerr = 0;
            for (int i = 0; i < 6; i++)
                if (q_data[i] !== exp_w[i]) nerr++;
            total++;
            if (nerr != 0) begin
                bad++;
                $display("FAIL surplus_words got %0d wrong words exp 0", nerr);
            end
        end
`ifdef SEQ_STATS_EN
        total++;
        if (drop_cnt !== 16'd2) begin
            bad++;
            $display("FAIL surplus_drop_cnt got=%0d exp=2", drop_cnt);
        end
`endif
    endtask

    task automatic test_early_last();
        int st;
        int n;
        int npad;
        do_reset();
        for (int i = 0; i < 8; i++) send(i / 4, 16'h1000 + 16'(i), 0, st);
        send(2, 16'h2200, 1, st);
        n = 0;
        while (q_done.size() == 0 || q_done[q_done.size() - 1] !== 1'b1) begin
            if (n >= 60) break;
            @(posedge clk);
            #1;
            n++;
        end
        total++;
        if (n >= 60) begin
            bad++;
            $display("FAIL early_done_timeout got none in 60 cycles exp pulse");
        end
        total++;
        if (q_data.size() !== 32) begin
            bad++;
            $display("FAIL early_count got=%0d exp=32", q_data.size());
        end else begin
            npad = 0;
            for (int i = 9; i < 32; i++)
                if (q_data[i] === 16'hFFFF && q_done[i] === (i == 31)) npad++;
            total++;
            if (q_data[8] !== 16'h2200) begin
                bad++;
                $display("FAIL early_data got=%h exp=2200", q_data[8]);
            end
            total++;
            if (npad != 23) begin
                bad++;
                $display("FAIL early_pads got=%0d good pads exp=23", npad);
            end
            total++;
            if (q_rdy[30] !== 1'b0 || q_rdy[31] !== 1'b1) begin
                bad++;
                $display("FAIL early_ready got=%b%b exp=01", q_rdy[30], q_rdy[31]);
            end
        end
`ifdef SEQ_STATS_EN
        total++;
        if (pad_cnt !== 16'd23) begin
            bad++;
            $display("FAIL early_pad_cnt got=%0d exp=23", pad_cnt);
        end
`endif
        send(0, 16'h3300, 0, st);
        drain(3);
        total++;
        if (q_data.size() !== 33 || q_data[q_data.size() - 1] !== 16'h3300) begin
            bad++;
            $display("FAIL early_next_acq got size=%0d exp 33 ending 3300",
                     q_data.size());
        end
    endtask

    task automatic test_reset_flush();
        int st;
        do_reset();
        send(0, 16'h4000, 1, st);
        drain(5);
        res = 1'b0;
        @(negedge clk);
        total++;
        if (wrEn !== 1'b0 || acq_done !== 1'b0) begin
            bad++;
            $display("FAIL flush_reset got wrEn=%b acq_done=%b exp 0 0",
                     wrEn, acq_done);
        end
        repeat (2) @(posedge clk);
        #1;
        res = 1'b1;
        clear_q();
        send(0, 16'h4400, 0, st);
        drain(3);
        total++;
        if (q_data.size() !== 1 || q_data[0] !== 16'h4400) begin
            bad++;
            $display("FAIL flush_restart got size=%0d first=%h exp 1 4400",
                     q_data.size(), q_data.size() > 0 ? q_data[0] : 16'h0);
        end
    endtask

    initial begin
        done_nowr = 0;
        test_reset();
        test_latency();
        test_full_acq();
        test_gap();
        test_surplus();
        test_early_last();
        test_reset_flush();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
